// File: rtl/fill_pkg.sv
// Shared definitions for the fill write/read path: descriptor field positions,
// FSM state encoding and the trailer marker word.
// The TRAILER state exists only when FILL_CHECKSUM_EN is defined.
package fill_pkg;

    localparam int DESC_W = 152;

    // Descriptor field positions (the read engine decodes with the same constants)
    localparam int DESC_BCNT_LSB  = 128;
    localparam int DESC_BCNT_MSB  = 151;
    localparam int DESC_TS_LSB    = 76;
    localparam int DESC_TS_MSB    = 127;
    localparam int DESC_START_LSB = 53;
    localparam int DESC_START_MSB = 75;
    localparam int DESC_WCNT_LSB  = 27;
    localparam int DESC_WCNT_MSB  = 52;
    localparam int DESC_ASYNC_BIT = 26;
    localparam int DESC_TYPE_LSB  = 24;
    localparam int DESC_TYPE_MSB  = 25;
    localparam int DESC_TRIG_LSB  = 0;
    localparam int DESC_TRIG_MSB  = 23;

    // Marker placed in the low word of the checksum trailer burst
    localparam logic [31:0] TRAILER_MAGIC = 32'hCAFE_F111;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PACK     = 3'd1,
        ST_WR_BURST = 3'd2,
        ST_DROP     = 3'd3,
        ST_WR_HDR   = 3'd4
`ifdef FILL_CHECKSUM_EN
        , ST_TRAILER = 3'd5
`endif
    } fill_state_e;

    // Assemble a fill descriptor from its fields
    function automatic logic [DESC_W-1:0] pack_desc(
        input logic [23:0] bcnt,
        input logic [51:0] ts,
        input logic [22:0] start,
        input logic [25:0] wcnt,
        input logic        async_m,
        input logic [1:0]  ftype,
        input logic [23:0] trig
    );
        logic [DESC_W-1:0] d;
        d = '0;
        d[DESC_BCNT_MSB:DESC_BCNT_LSB]   = bcnt;
        d[DESC_TS_MSB:DESC_TS_LSB]       = ts;
        d[DESC_START_MSB:DESC_START_LSB] = start;
        d[DESC_WCNT_MSB:DESC_WCNT_LSB]   = wcnt;
        d[DESC_ASYNC_BIT]                = async_m;
        d[DESC_TYPE_MSB:DESC_TYPE_LSB]   = ftype;
        d[DESC_TRIG_MSB:DESC_TRIG_LSB]   = trig;
        return d;
    endfunction

endpackage

// File: rtl/fill_word_packer.sv
// 4-lane 32->128 word packer. Word n of a burst lands in [32n+31:32n]; a word
// flagged last zeroes every lane above it. Packed data stays put until the
// next write so the burst can be held on the DDR3 bus during stalls.
module fill_word_packer (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [31:0]  word,
    input  logic         last,
    output logic [127:0] data,
    output logic         done
);

    logic [1:0]   lane_q, lane_d;
    logic [127:0] data_q, data_d;

    assign done = wr_en && (lane_q == 2'd3 || last);
    assign data = data_q;

    // Lane insert with zero-fill above the last word; lane pointer restarts per burst
    always_comb begin
        data_d = data_q;
        lane_d = lane_q;
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i == int'(lane_q))
                    data_d[32*i +: 32] = word;
                else if (last && i > int'(lane_q))
                    data_d[32*i +: 32] = 32'h0;
            end
            lane_d = done ? 2'd0 : lane_q + 2'd1;
        end
    end

    // Packer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q <= 2'd0;
            data_q <= '0;
        end else begin
            lane_q <= lane_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/fill_wr_sm.sv
// Fill write state machine: packs the ADC word stream of one fill into 128-bit
// bursts, writes them at a circular DDR3 write pointer and pushes one
// descriptor per fill into the fill header FIFO.
// Optional feature macro: FILL_CHECKSUM_EN adds a checksum trailer burst.
module fill_wr_sm
    import fill_pkg::*;
#(
    parameter logic [22:0] BUF_LAST_ADDR = 23'h7FFFFF,
    parameter logic [23:0] MAX_BURSTS    = 24'd262144
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         async_mode,
    input  logic [1:0]   fill_type,
    input  logic [51:0]  timestamp,
    input  logic [31:0]  s_tdata,
    input  logic         s_tvalid,
    input  logic         s_tlast,
    output logic         s_tready,
    output logic [22:0]  ddr3_wr_addr,
    output logic [127:0] ddr3_wr_data,
    output logic         ddr3_wr_valid,
    input  logic         ddr3_wr_ready,
    input  logic         fill_header_fifo_full,
    output logic         fill_header_fifo_wr_en,
    output logic [151:0] fill_header_fifo_in,
    output logic         fill_overflow
);

`ifdef FILL_CHECKSUM_EN
    // One burst of the budget is reserved for the trailer
    localparam logic [23:0] DATA_BUDGET = MAX_BURSTS - 24'd1;
    localparam fill_state_e END_ST      = ST_TRAILER;
`else
    localparam logic [23:0] DATA_BUDGET = MAX_BURSTS;
    localparam fill_state_e END_ST      = ST_WR_HDR;
`endif

    fill_state_e  state_q, state_d;
    logic [22:0]  wr_ptr_q, wr_ptr_d;
    logic [22:0]  start_q, start_d;
    logic [23:0]  burst_cnt_q, burst_cnt_d;
    logic [25:0]  word_cnt_q, word_cnt_d;
    logic [51:0]  ts_q, ts_d;
    logic         async_q, async_d;
    logic [1:0]   type_q, type_d;
    logic [23:0]  trig_q, trig_d;
    logic         ovf_q, ovf_d;
    logic         ended_q, ended_d;
`ifdef FILL_CHECKSUM_EN
    logic [31:0]  cksum_q, cksum_d;
`endif

    logic         pk_wr;
    logic         pk_done;
    logic [127:0] pk_data;
    logic [22:0]  ptr_inc;

    assign pk_wr   = (state_q == ST_PACK) && s_tvalid;
    assign ptr_inc = (wr_ptr_q == BUF_LAST_ADDR) ? 23'd0 : wr_ptr_q + 23'd1;

    fill_word_packer u_packer (
        .clk   (clk),
        .reset (reset),
        .wr_en (pk_wr),
        .word  (s_tdata),
        .last  (s_tlast),
        .data  (pk_data),
        .done  (pk_done)
    );

    assign ddr3_wr_addr  = wr_ptr_q;
    assign fill_overflow = ovf_q;
`ifdef FILL_CHECKSUM_EN
    assign ddr3_wr_data  = (state_q == ST_TRAILER)
                         ? {32'h0, 6'h0, word_cnt_q, cksum_q, TRAILER_MAGIC}
                         : pk_data;
`else
    assign ddr3_wr_data  = pk_data;
`endif
    assign fill_header_fifo_in = pack_desc(burst_cnt_q, ts_q, start_q, word_cnt_q,
                                           async_q, type_q, trig_q);

    // Next-state and handshake outputs
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        start_d     = start_q;
        burst_cnt_d = burst_cnt_q;
        word_cnt_d  = word_cnt_q;
        ts_d        = ts_q;
        async_d     = async_q;
        type_d      = type_q;
        trig_d      = trig_q;
        ovf_d       = ovf_q;
        ended_d     = ended_q;
`ifdef FILL_CHECKSUM_EN
        cksum_d     = cksum_q;
`endif
        s_tready               = 1'b0;
        ddr3_wr_valid          = 1'b0;
        fill_header_fifo_wr_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    start_d     = async_mode ? 23'd0 : wr_ptr_q;
                    wr_ptr_d    = async_mode ? 23'd0 : wr_ptr_q;
                    burst_cnt_d = 24'd0;
                    word_cnt_d  = 26'd0;
                    async_d     = async_mode;
                    type_d      = fill_type;
                    ovf_d       = 1'b0;
                    ended_d     = 1'b0;
`ifdef FILL_CHECKSUM_EN
                    cksum_d     = 32'h0;
`endif
                    if (DATA_BUDGET == 24'd0) begin
                        state_d = ST_DROP;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = ST_PACK;
                    end
                end
            end
            ST_PACK: begin
                s_tready = 1'b1;
                if (s_tvalid) begin
                    word_cnt_d = word_cnt_q + 26'd1;
                    if (word_cnt_q == 26'd0)
                        ts_d = timestamp;
`ifdef FILL_CHECKSUM_EN
                    cksum_d = cksum_q + s_tdata;
`endif
                    if (s_tlast)
                        ended_d = 1'b1;
                    if (pk_done)
                        state_d = ST_WR_BURST;
                end
            end
            ST_WR_BURST: begin
                ddr3_wr_valid = 1'b1;
                if (ddr3_wr_ready) begin
                    burst_cnt_d = burst_cnt_q + 24'd1;
                    wr_ptr_d    = ptr_inc;
                    if (ended_q) begin
                        state_d = END_ST;
                    end else if (burst_cnt_q + 24'd1 >= DATA_BUDGET) begin
                        // Budget exhausted with the fill still running
                        state_d = ST_DROP;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = ST_PACK;
                    end
                end
            end
            ST_DROP: begin
                s_tready = 1'b1;
                if (s_tvalid && s_tlast)
                    state_d = END_ST;
            end
`ifdef FILL_CHECKSUM_EN
            ST_TRAILER: begin
                ddr3_wr_valid = 1'b1;
                if (ddr3_wr_ready) begin
                    burst_cnt_d = burst_cnt_q + 24'd1;
                    wr_ptr_d    = ptr_inc;
                    state_d     = ST_WR_HDR;
                end
            end
`endif
            ST_WR_HDR: begin
                if (!fill_header_fifo_full) begin
                    fill_header_fifo_wr_en = 1'b1;
                    trig_d  = trig_q + 24'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and fill bookkeeping registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= 23'd0;
            start_q     <= 23'd0;
            burst_cnt_q <= 24'd0;
            word_cnt_q  <= 26'd0;
            ts_q        <= 52'd0;
            async_q     <= 1'b0;
            type_q      <= 2'd0;
            trig_q      <= 24'd0;
            ovf_q       <= 1'b0;
            ended_q     <= 1'b0;
`ifdef FILL_CHECKSUM_EN
            cksum_q     <= 32'h0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            start_q     <= start_d;
            burst_cnt_q <= burst_cnt_d;
            word_cnt_q  <= word_cnt_d;
            ts_q        <= ts_d;
            async_q     <= async_d;
            type_q      <= type_d;
            trig_q      <= trig_d;
            ovf_q       <= ovf_d;
            ended_q     <= ended_d;
`ifdef FILL_CHECKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

endmodule

// File: tb/tb_fill_wr_sm.sv
// Randomized bench for fill_wr_sm with a fill-level reference model:
// expected bursts, addresses and descriptor are derived from the word list.
module tb_fill_wr_sm;

    localparam logic [22:0] LAST = 23'd13;
    localparam logic [23:0] MAXB = 24'd5;
`ifdef FILL_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int NADDR   = int'(LAST) + 1;
    localparam int DBUDGET = int'(MAXB) - CK;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         async_mode = 1'b0;
    logic [1:0]   fill_type = 2'd0;
    logic [51:0]  timestamp = 52'h1_2345_6789_A;
    logic [31:0]  s_tdata = 32'h0;
    logic         s_tvalid = 1'b0;
    logic         s_tlast = 1'b0;
    logic         s_tready;
    logic [22:0]  ddr3_wr_addr;
    logic [127:0] ddr3_wr_data;
    logic         ddr3_wr_valid;
    logic         ddr3_wr_ready = 1'b0;
    logic         fill_header_fifo_full = 1'b0;
    logic         fill_header_fifo_wr_en;
    logic [151:0] fill_header_fifo_in;
    logic         fill_overflow;

    fill_wr_sm #(.BUF_LAST_ADDR(LAST), .MAX_BURSTS(MAXB)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .enable                 (enable),
        .async_mode             (async_mode),
        .fill_type              (fill_type),
        .timestamp              (timestamp),
        .s_tdata                (s_tdata),
        .s_tvalid               (s_tvalid),
        .s_tlast                (s_tlast),
        .s_tready               (s_tready),
        .ddr3_wr_addr           (ddr3_wr_addr),
        .ddr3_wr_data           (ddr3_wr_data),
        .ddr3_wr_valid          (ddr3_wr_valid),
        .ddr3_wr_ready          (ddr3_wr_ready),
        .fill_header_fifo_full  (fill_header_fifo_full),
        .fill_header_fifo_wr_en (fill_header_fifo_wr_en),
        .fill_header_fifo_in    (fill_header_fifo_in),
        .fill_overflow          (fill_overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int m_ptr = 0;
    int m_trig = 0;

    task automatic chk(input string tag, input logic [151:0] got, input logic [151:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_tready"}, s_tready, 0);
        chk({pfx, "_valid"}, ddr3_wr_valid, 0);
        chk({pfx, "_addr"}, ddr3_wr_addr, 0);
        chk({pfx, "_data"}, ddr3_wr_data, 0);
        chk({pfx, "_wr_en"}, fill_header_fifo_wr_en, 0);
        chk({pfx, "_desc"}, fill_header_fifo_in, 0);
        chk({pfx, "_ovf"}, fill_overflow, 0);
    endtask

    // Drive one fill end to end, capture everything the DUT emits, then
    // compare against the expected fill image.
    task automatic run_fill(input int n, input bit seq, input bit am, input logic [1:0] ft,
                            input int rdy_pct, input int full_hold);
        logic [31:0]  words[$];
        logic [22:0]  cap_addr[$];
        logic [127:0] cap_data[$];
        logic [151:0] cap_desc;
        logic [51:0]  ts_first;
        logic [22:0]  prev_addr;
        logic [127:0] prev_data;
        logic [127:0] e;
        logic [31:0]  sum;
        bit prev_stall, cur_v;
        int wi, cyc, n_push, post, full_left, full_bad;
        int cap_words, nb_data, nb, start;
        bit ovf;

        for (int i = 0; i < n; i++) words.push_back(seq ? 32'(i + 1) : $urandom);
        wi = 0; cyc = 0; n_push = 0; post = 0; full_bad = 0;
        full_left = full_hold; prev_stall = 0; cur_v = 0;
        cap_desc = '0; ts_first = '0; prev_addr = '0; prev_data = '0;
        async_mode = am;
        fill_type = ft;

        while (cyc < 3000 && !(n_push > 0 && post >= 3)) begin
            @(negedge clk);
            cyc++;
            timestamp = timestamp + 52'(1 + $urandom_range(0, 3));
            enable = (cyc == 1);
            if (!cur_v && wi < n && $urandom_range(0, 3) != 0) cur_v = 1;
            s_tvalid = cur_v;
            s_tdata  = (wi < n) ? words[wi] : 32'h0;
            s_tlast  = cur_v && (wi == n - 1);
            ddr3_wr_ready = ($urandom_range(0, 99) < rdy_pct);
            if (wi == n && full_left > 0) begin
                fill_header_fifo_full = 1'b1;
                full_left--;
            end else begin
                fill_header_fifo_full = 1'b0;
            end
            #1;
            if (prev_stall) begin
                chk("stall_valid", ddr3_wr_valid, 1);
                chk("stall_addr", ddr3_wr_addr, prev_addr);
                chk("stall_data", ddr3_wr_data, prev_data);
            end
            prev_stall = ddr3_wr_valid && !ddr3_wr_ready;
            prev_addr  = ddr3_wr_addr;
            prev_data  = ddr3_wr_data;
            if (ddr3_wr_valid && ddr3_wr_ready) begin
                cap_addr.push_back(ddr3_wr_addr);
                cap_data.push_back(ddr3_wr_data);
            end
            if (fill_header_fifo_wr_en) begin
                if (fill_header_fifo_full) full_bad++;
                n_push++;
                cap_desc = fill_header_fifo_in;
            end
            if (s_tvalid && s_tready) begin
                if (wi == 0) ts_first = timestamp;
                wi++;
                cur_v = 0;
            end
            if (n_push > 0) post++;
        end
        s_tvalid = 0;
        s_tlast  = 0;
        fill_header_fifo_full = 0;

        // Expected fill image from the word list
        cap_words = (n > 4 * DBUDGET) ? 4 * DBUDGET : n;
        ovf       = (n > 4 * DBUDGET);
        nb_data   = (cap_words + 3) / 4;
        nb        = nb_data + CK;
        start     = am ? 0 : m_ptr;
        sum       = 32'h0;
        for (int i = 0; i < cap_words; i++) sum = sum + words[i];

        chk("words_accepted", wi, n);
        chk("push_count", n_push, 1);
        chk("push_while_full", full_bad, 0);
        chk("burst_count", cap_addr.size(), nb);
        for (int b = 0; b < nb && b < cap_addr.size(); b++) begin
            e = '0;
            if (b < nb_data) begin
                for (int l = 0; l < 4; l++)
                    if (4 * b + l < cap_words) e[32*l +: 32] = words[4*b + l];
            end else begin
                e = {32'h0, 32'(cap_words), sum, 32'hCAFE_F111};
            end
            chk($sformatf("burst%0d_addr", b), cap_addr[b], 23'((start + b) % NADDR));
            chk($sformatf("burst%0d_data", b), cap_data[b], e);
        end
        chk("desc", cap_desc, {24'(nb), ts_first, 23'(start), 26'(cap_words), am, ft, 24'(m_trig)});
        chk("overflow", fill_overflow, ovf);

        m_ptr  = (start + nb) % NADDR;
        m_trig = (m_trig + 1) % (1 << 24);
    endtask

    // Abandon a fill with reset while a burst is stalled
    task automatic reset_mid_fill();
        int pushes;
        pushes = 0;
        @(negedge clk);
        enable = 1; async_mode = 0; ddr3_wr_ready = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            enable = 0; s_tvalid = 1; s_tdata = $urandom; s_tlast = 0;
        end
        reset = 1;
        #1;
        chk_quiet("rst_mid");
        @(negedge clk);
        @(negedge clk);
        reset = 0; s_tvalid = 0; ddr3_wr_ready = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (fill_header_fifo_wr_en) pushes++;
        end
        chk("rst_no_push", pushes, 0);
        m_ptr  = 0;
        m_trig = 0;
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk_quiet("rst0");
        @(negedge clk);
        reset = 0;

        run_fill(8, 1, 0, 2'd1, 100, 0);   // two full bursts at 0,1
        run_fill(5, 1, 0, 2'd2, 100, 0);   // partial second burst, zero-filled
        run_fill(5, 1, 1, 2'd3, 100, 0);   // async: back to address 0
        run_fill(12, 1, 0, 2'd0, 50, 0);   // ready toggling
        run_fill(4, 1, 0, 2'd1, 100, 0);   // exactly one burst (trailer case)
        run_fill(28, 1, 0, 2'd2, 70, 0);   // exceeds the burst cap
        run_fill(6, 0, 0, 2'd3, 100, 50);  // header FIFO full for 50 cycles
        run_fill(4 * DBUDGET, 0, 0, 2'd0, 80, 0); // fills the cap exactly

        for (int t = 0; t < 30; t++)
            run_fill($urandom_range(1, 26), 0, ($urandom_range(0, 4) == 0),
                     2'($urandom_range(0, 3)), $urandom_range(30, 100), $urandom_range(0, 4));

        reset_mid_fill();
        run_fill(7, 1, 0, 2'd2, 100, 0);   // pointer and trigger restart from 0

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
